// File: rtl/sm_accum_disp.sv
// Sign-magnitude accumulator driven by button edges, with a 4-digit multiplexed
// 7-segment display showing magnitude (hex), sign and sticky overflow.
module sm_accum_disp #(
    parameter int N            = 8,
    parameter int REFRESH_BITS = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        btn,
    input  logic [N-1:0]      sw,
    output logic [3:0]        an,
    output logic [7:0]        sseg,
    output logic [N-1:0]      acc,
    output logic              ovf
);

    localparam int M = N - 1;

    logic [2:0]              btn_q;
    logic [2:0]              rise;
    logic [N-1:0]            acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] refresh_q;

    logic [M-1:0]            b_mag;
    logic                    b_sign;
    logic                    op_sign;
    logic [M:0]              mag_sum;
    logic [M-1:0]            res_mag;
    logic                    res_sign;
    logic                    res_carry;
    logic [7:0]              mag8;
    logic [1:0]              digit_sel;

    assign rise = btn & ~btn_q;

    // A zero-magnitude operand is always +0 so it never flips the result sign.
    assign b_mag   = sw[M-1:0];
    assign b_sign  = sw[N-1] & (|b_mag);
    assign op_sign = rise[1] ? b_sign : (~b_sign & (|b_mag));
    assign mag_sum = {1'b0, acc_q[M-1:0]} + {1'b0, b_mag};

    always_comb begin
        res_mag   = '0;
        res_sign  = 1'b0;
        res_carry = 1'b0;
        if (acc_q[N-1] == op_sign) begin
            res_mag   = mag_sum[M-1:0];
            res_sign  = op_sign;
            res_carry = mag_sum[M];
        end else if (acc_q[M-1:0] >= b_mag) begin
            res_mag  = acc_q[M-1:0] - b_mag;
            res_sign = acc_q[N-1];
        end else begin
            res_mag  = b_mag - acc_q[M-1:0];
            res_sign = op_sign;
        end
        // Keeps the accumulator free of -0, including after a wrap.
        res_sign = res_sign & (|res_mag);
    end

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (rise[0]) begin
            acc_d = {b_sign, b_mag};
            ovf_d = 1'b0;
        end else if (rise[1] || rise[2]) begin
            acc_d = {res_sign, res_mag};
            ovf_d = ovf_q | res_carry;
        end
    end

    // Buttons reset to "pressed" so a button held through reset is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q     <= 3'b111;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            refresh_q <= '0;
        end else begin
            btn_q     <= btn;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            refresh_q <= refresh_q + 1'b1;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] seg;
        case (h)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign digit_sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        mag8         = '0;
        mag8[M-1:0]  = acc_q[M-1:0];
        an           = 4'b1111;
        sseg         = 8'b11111111;
        case (digit_sel)
            2'd0: begin
                an   = 4'b1110;
                sseg = {1'b1, hex7(mag8[3:0])};
            end
            2'd1: begin
                an   = 4'b1101;
                sseg = {1'b1, hex7(mag8[7:4])};
            end
            2'd2: begin
                an   = 4'b1011;
                sseg = acc_q[N-1] ? 8'b11111110 : 8'b11111111;
            end
            default: begin
                an   = 4'b0111;
                sseg = ovf_q ? 8'b10111000 : 8'b11111111;
            end
        endcase
    end

endmodule
